// File: rtl/ag_vram_arbiter_if.sv
// CPU byte port and video burst/FIFO port of the shared video RAM arbiter.
// The slave modport faces the arbiter; the master modport faces the bus decoder and video controller.
interface ag_vram_arbiter_if #(
   parameter int BYTE_W = 8,
   parameter int LANES  = 2,
   parameter int WAW    = 14,
   parameter int LW     = 8
);
   localparam int AW = WAW + $clog2(LANES);

   logic                    cpu_req;
   logic                    cpu_we;
   logic [AW-1:0]           cpu_addr;
   logic [BYTE_W-1:0]       cpu_wdata;
   logic [BYTE_W-1:0]       cpu_rdata;
   logic                    cpu_ack;
   logic                    vid_start;
   logic [WAW-1:0]          vid_base;
   logic [LW-1:0]           vid_len;
   logic                    vid_rd;
   logic [LANES*BYTE_W-1:0] vid_data;
   logic                    vid_valid;
   logic                    vid_busy;
   logic                    vid_underrun;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_start, vid_base, vid_len, vid_rd,
      input  cpu_rdata, cpu_ack, vid_data, vid_valid, vid_busy, vid_underrun
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_start, vid_base, vid_len, vid_rd,
      output cpu_rdata, cpu_ack, vid_data, vid_valid, vid_busy, vid_underrun
   );
endinterface

// File: rtl/ag_vram_arbiter.sv
// Single-port video RAM shared between a byte-wide CPU port and a burst prefetch engine
// that fills a small FIFO; one array access per cycle, CPU preferred unless video is urgent.
module ag_vram_arbiter #(
   parameter int BYTE_W     = 8,
   parameter int LANES      = 2,
   parameter int WAW        = 14,
   parameter int LW         = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int LOW_WM     = 1
) (
   input logic              CLK,
   input logic              RST_N,
   ag_vram_arbiter_if.slave bus
);
   localparam int WW  = LANES * BYTE_W;
   localparam int LB  = $clog2(LANES);
   localparam int LBW = (LB > 0) ? LB : 1;
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 2;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   logic [WW-1:0]     mem [2**WAW];

   state_t            state_q, state_d;
   logic [WAW-1:0]    ptr_q, ptr_d;
   logic [LW-1:0]     rem_q, rem_d;
   logic              inflight_q, inflight_d;
   logic [WW-1:0]     rd_word_q, rd_word_d;
   logic [WW-1:0]     fifo_q [FIFO_DEPTH];
   logic [WW-1:0]     fifo_d [FIFO_DEPTH];
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW:0]       count_q, count_d;
   logic              preempt_q, preempt_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic [BYTE_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              underrun_q, underrun_d;

   logic [WAW-1:0]    cpu_word;
   logic [LBW-1:0]    cpu_lane;
   logic [CW-1:0]     credit;
   logic              cpu_pending, vid_req, vid_urgent, grant_vid, grant_cpu, push, pop;
   logic [WAW-1:0]    slot_addr;
   logic [WW-1:0]     slot_word;

   assign cpu_word = WAW'(bus.cpu_addr >> LB);

   generate
      if (LB > 0) begin : g_lane
         assign cpu_lane = bus.cpu_addr[LBW-1:0];
      end else begin : g_nolane
         assign cpu_lane = '0;
      end
   endgenerate

   // A request seen during its own ack cycle is the old one still held, not a new access.
   always_comb begin
      cpu_pending = bus.cpu_req && !cpu_ack_q;
      credit      = CW'(count_q) + CW'(inflight_q);
      vid_req     = (state_q == FETCH) && (rem_q != '0) && (credit < CW'(FIFO_DEPTH));
      vid_urgent  = credit <= CW'(LOW_WM);
      grant_vid   = vid_req && (!cpu_pending || (vid_urgent && !preempt_q));
      grant_cpu   = cpu_pending && !grant_vid;
      slot_addr   = grant_vid ? ptr_q : cpu_word;
   end

   assign slot_word = mem[slot_addr];

   always_ff @(posedge CLK) begin
      if (RST_N && grant_cpu && bus.cpu_we) begin
         for (int k = 0; k < LANES; k++) begin
            if (cpu_lane == LBW'(k)) begin
               mem[cpu_word][(LANES-1-k)*BYTE_W +: BYTE_W] <= bus.cpu_wdata;
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      rem_d       = rem_q;
      fifo_d      = fifo_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      cpu_rdata_d = cpu_rdata_q;
      rd_word_d   = rd_word_q;

      cpu_ack_d   = grant_cpu;
      preempt_d   = grant_vid && cpu_pending;
      inflight_d  = grant_vid;
      push        = inflight_q;
      pop         = bus.vid_rd && (count_q != '0);
      underrun_d  = bus.vid_rd && (count_q == '0);

      if (grant_cpu && !bus.cpu_we) begin
         cpu_rdata_d = slot_word[(LANES-1-int'(cpu_lane))*BYTE_W +: BYTE_W];
      end
      if (grant_vid) begin
         rd_word_d = slot_word;
      end

      // Credit accounting in vid_req guarantees a push never lands on a full FIFO.
      if (push) begin
         fifo_d[wr_ptr_q] = rd_word_q;
         wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + (PW+1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (PW+1)'(1);
      end

      case (state_q)
         IDLE: begin
            if (bus.vid_start && (bus.vid_len != '0)) begin
               ptr_d   = bus.vid_base;
               rem_d   = bus.vid_len;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (grant_vid) begin
               ptr_d = ptr_q + WAW'(1);
               rem_d = rem_q - LW'(1);
               if (rem_q == LW'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if ((count_q == '0) && !inflight_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      valid_d = (count_d != '0);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         rem_q       <= '0;
         inflight_q  <= 1'b0;
         rd_word_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         preempt_q   <= 1'b0;
         cpu_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         rem_q       <= rem_d;
         inflight_q  <= inflight_d;
         rd_word_q   <= rd_word_d;
         fifo_q      <= fifo_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         preempt_q   <= preempt_d;
         cpu_ack_q   <= cpu_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         underrun_q  <= underrun_d;
      end
   end

   assign bus.cpu_ack      = cpu_ack_q;
   assign bus.cpu_rdata    = cpu_rdata_q;
   assign bus.vid_data     = fifo_q[rd_ptr_q];
   assign bus.vid_valid    = valid_q;
   assign bus.vid_busy     = busy_q;
   assign bus.vid_underrun = underrun_q;
endmodule

// File: tb/tb_ag_vram_arbiter.sv
// Scoreboard bench for the video RAM arbiter: expected CPU bytes and video words are queued
// when stimulus is driven and compared when the DUT acks or the FIFO head is popped.
module tb_ag_vram_arbiter;
   logic CLK = 1'b0;
   logic RST_N;
   int   testsRun = 0;
   int   testsFailed = 0;

   logic [15:0] modelMem [16384];
   logic [8:0]  cpuExpQ [$];
   logic [15:0] vidExpQ [$];
   logic [8:0]  monExp;
   logic [15:0] planExp [16];

   ag_vram_arbiter_if #(.BYTE_W(8), .LANES(2), .WAW(14), .LW(8)) bus ();

   ag_vram_arbiter #(
      .BYTE_W(8), .LANES(2), .WAW(14), .LW(8), .FIFO_DEPTH(4), .LOW_WM(1)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   function automatic logic [7:0] modelByte(input logic [14:0] a);
      logic [15:0] w;
      w = modelMem[a[14:1]];
      return a[0] ? w[7:0] : w[15:8];
   endfunction

   // Scoreboard side: CPU acks and video pops are matched against queued expectations.
   always @(negedge CLK) begin
      if (RST_N && bus.cpu_ack) begin
         if (cpuExpQ.size() == 0) begin
            checkOutput("cpu_unexpected_ack", 32'd1, 32'd0);
         end else begin
            monExp = cpuExpQ.pop_front();
            if (monExp[8]) checkOutput("cpu_rdata", {24'd0, bus.cpu_rdata}, {24'd0, monExp[7:0]});
         end
      end
      if (RST_N && bus.vid_rd && bus.vid_valid) begin
         if (vidExpQ.size() == 0) begin
            checkOutput("vid_unexpected_pop", 32'd1, 32'd0);
         end else begin
            checkOutput("vid_data", {16'd0, bus.vid_data}, {16'd0, vidExpQ.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic cpuIdle();
      bus.cpu_req = 1'b0;
      bus.cpu_we  = 1'b0;
   endtask

   // One CPU transaction; returns in the cycle after the ack with the request still raised.
   task automatic applyStimulus(input logic we, input logic [14:0] addr, input logic [7:0] wdata, output int lat);
      bit got;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      if (we) begin
         cpuExpQ.push_back({1'b0, 8'h00});
         if (addr[0]) modelMem[addr[14:1]][7:0] = wdata;
         else         modelMem[addr[14:1]][15:8] = wdata;
      end else begin
         cpuExpQ.push_back({1'b1, modelByte(addr)});
      end
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (bus.cpu_ack) begin
            got = 1'b1;
            break;
         end
         lat++;
      end
      if (!got) begin
         checkOutput("cpu_ack_timeout", 32'd0, 32'd1);
         cpuIdle();
      end
      tick();
   endtask

   task automatic startBurst(input logic [13:0] base, input logic [7:0] len, input bit pushExp);
      logic [13:0] a;
      bus.vid_start = 1'b1;
      bus.vid_base  = base;
      bus.vid_len   = len;
      if (pushExp) begin
         for (int i = 0; i < int'(len); i++) begin
            a = base + 14'(i);
            vidExpQ.push_back(modelMem[a]);
         end
      end
      tick();
      bus.vid_start = 1'b0;
   endtask

   task automatic waitValid(input string tag);
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (bus.vid_valid) break;
      end
      checkOutput(tag, {31'd0, bus.vid_valid}, 32'd1);
      tick();
   endtask

   task automatic popWords(input int n);
      int got;
      got = 0;
      bus.vid_rd = 1'b1;
      for (int i = 0; i < 200 && got < n; i++) begin
         @(negedge CLK);
         if (bus.vid_valid) got++;
      end
      if (got < n) checkOutput("vid_pop_timeout", got, n);
      tick();
      bus.vid_rd = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      logic [13:0] wrapWords [4];

      RST_N         = 1'b0;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.vid_start = 1'b0;
      bus.vid_base  = '0;
      bus.vid_len   = '0;
      bus.vid_rd    = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checkOutput("rst_cpu_ack",   {31'd0, bus.cpu_ack},      32'd0);
      checkOutput("rst_cpu_rdata", {24'd0, bus.cpu_rdata},    32'd0);
      checkOutput("rst_vid_valid", {31'd0, bus.vid_valid},    32'd0);
      checkOutput("rst_vid_busy",  {31'd0, bus.vid_busy},     32'd0);
      checkOutput("rst_underrun",  {31'd0, bus.vid_underrun}, 32'd0);
      checkOutput("rst_vid_data",  {16'd0, bus.vid_data},     32'd0);
      tick();
      RST_N = 1'b1;
      tick();

      // Lane mapping: byte 0 lands in the upper half of word 0.
      applyStimulus(1'b1, 15'h0000, 8'hA5, lat);
      applyStimulus(1'b1, 15'h0001, 8'h5A, lat);
      cpuIdle();
      startBurst(14'h0000, 8'd1, 1'b1);
      waitValid("t1_valid_rise");
      checkOutput("t1_busy_before_pop", {31'd0, bus.vid_busy}, 32'd1);
      popWords(1);
      tick();
      @(negedge CLK);
      checkOutput("t1_busy_after_pop", {31'd0, bus.vid_busy}, 32'd0);
      tick();

      applyStimulus(1'b0, 15'h0001, 8'h00, lat);
      cpuIdle();
      checkOutput("t2_read_latency", lat, 32'd1);
      applyStimulus(1'b1, 15'h0001, 8'hFF, lat);
      cpuIdle();
      checkOutput("t2_write_latency", lat, 32'd1);
      startBurst(14'h0000, 8'd1, 1'b1);
      waitValid("t2_valid");
      popWords(1);

      // Burst across the top of the address space.
      wrapWords[0] = 14'h3FFE;
      wrapWords[1] = 14'h3FFF;
      wrapWords[2] = 14'h0000;
      wrapWords[3] = 14'h0001;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, {wrapWords[i], 1'b0}, 8'h10 + 8'(2*i), lat);
         applyStimulus(1'b1, {wrapWords[i], 1'b1}, 8'h11 + 8'(2*i), lat);
      end
      cpuIdle();
      startBurst(14'h3FFE, 8'd4, 1'b1);
      waitValid("t3_valid");
      popWords(4);

      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, {14'h100 + 14'(i), 1'b0}, 8'hC0 + 8'(i), lat);
         applyStimulus(1'b1, {14'h100 + 14'(i), 1'b1}, 8'h30 + 8'(i), lat);
      end
      cpuIdle();
      // Words 0..3 are fetched before the later writes; word 4 must show the new byte.
      for (int i = 0; i < 16; i++) planExp[i] = modelMem[14'h100 + 14'(i)];
      planExp[4][15:8] = 8'hDD;
      for (int i = 0; i < 16; i++) vidExpQ.push_back(planExp[i]);
      startBurst(14'h0100, 8'd16, 1'b0);
      for (int j = 0; j < 12; j++) begin
         applyStimulus(1'b0, 15'h0200 + 15'(j), 8'h00, lat);
         checkOutput("t4_cpu_lat_le2", {31'd0, lat <= 2}, 32'd1);
      end
      cpuIdle();
      checkOutput("t4_video_progress", {31'd0, bus.vid_valid}, 32'd1);
      repeat (20) tick();
      applyStimulus(1'b1, {14'h103, 1'b0}, 8'hEE, lat);
      applyStimulus(1'b1, {14'h104, 1'b0}, 8'hDD, lat);
      cpuIdle();
      checkOutput("t4_busy_while_full", {31'd0, bus.vid_busy}, 32'd1);
      popWords(16);

      repeat (3) tick();
      bus.vid_rd = 1'b1;
      tick();
      bus.vid_rd = 1'b0;
      @(negedge CLK);
      checkOutput("t5_underrun_pulse", {31'd0, bus.vid_underrun}, 32'd1);
      checkOutput("t5_valid_empty",    {31'd0, bus.vid_valid},    32'd0);
      tick();
      @(negedge CLK);
      checkOutput("t5_underrun_clear", {31'd0, bus.vid_underrun}, 32'd0);
      tick();
      startBurst(14'h0000, 8'd0, 1'b1);
      tick();
      @(negedge CLK);
      checkOutput("t5_len0_busy",  {31'd0, bus.vid_busy},  32'd0);
      checkOutput("t5_len0_valid", {31'd0, bus.vid_valid}, 32'd0);
      tick();

      // Reset in the middle of a burst drops all queued video data.
      startBurst(14'h0100, 8'd8, 1'b1);
      waitValid("t6_valid");
      tick();
      RST_N = 1'b0;
      #1;
      checkOutput("t6_rst_valid",   {31'd0, bus.vid_valid}, 32'd0);
      checkOutput("t6_rst_busy",    {31'd0, bus.vid_busy},  32'd0);
      checkOutput("t6_rst_vid_data", {16'd0, bus.vid_data}, 32'd0);
      vidExpQ.delete();
      tick();
      tick();
      RST_N = 1'b1;
      tick();
      startBurst(14'h0000, 8'd1, 1'b1);
      waitValid("t6_valid_after_reset");
      popWords(1);
      repeat (3) tick();

      checkOutput("vid_queue_drained", vidExpQ.size(), 32'd0);
      checkOutput("cpu_queue_drained", cpuExpQ.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
